multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multicycle MIPS-style core: decodes the registered state into datapath
// strobes and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state_out,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11,
    StIllegal  = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;

  // Branch resolution uses zero inside the datapath, gated by pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_q + {{(CNT_W-1){1'b0}}, instr_done};
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OpRType:    state_d = StRExec;
          OpLw, OpSw: state_d = StMemAddr;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiExec;
          default:    state_d = StIllegal;
        endcase
      end
      StMemAddr: begin
        if (opcode == OpLw)      state_d = StMemRead;
        else if (opcode == OpSw) state_d = StMemWrite;
        else                     state_d = StFetch;
      end
      StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
      StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
      StRExec:    state_d = StRWb;
      StAddiExec: state_d = StAddiWb;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      StFetch: begin
        // IR load and PC increment only on the completing cycle of the fetch.
        mem_req   = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_b = 2'b01;
      end
      StDecode:  alu_src_b = 2'b11;
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRead: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      StMemWrite: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StRWb: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      StJump: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      StAddiExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StAddiWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StIllegal: illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign state_out     = state_q;
  assign retired_count = retired_q;

endmodule
